// File: rtl/exception_unit.sv
// rtl/exception_unit.sv - precise-exception unit with CP0 state and Count/Compare timer
// Prioritises M-stage exceptions and interrupts, drives flush/redirect, owns CP0 registers.
module exception_unit #(
  parameter int          HW_INT_NUM   = 6,
  parameter logic [31:0] EXC_VECTOR   = 32'hbfc0_0380,
  parameter logic [31:0] RESET_STATUS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  stall,
  input  logic                  inst_valid,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic                  ri,
  input  logic                  brk,
  input  logic                  syscall,
  input  logic                  overflow,
  input  logic                  adel_inst,
  input  logic                  adel_data,
  input  logic                  ades,
  input  logic                  eret,
  input  logic                  in_delayslot,
  input  logic [31:0]           pc,
  input  logic [31:0]           bad_addr_data,
  input  logic                  mtc0_en,
  input  logic [4:0]            cp0_waddr,
  input  logic [31:0]           cp0_wdata,
  input  logic [4:0]            cp0_raddr,
  output logic [31:0]           cp0_rdata,
  output logic                  flush,
  output logic [31:0]           pc_except,
  output logic [4:0]            exc_code,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o
);

  localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;

  logic [31:0] status_r, epc_r, badvaddr_r, count_r, compare_r;
  logic        cause_bd, ti, tick;
  logic [5:0]  ip_hw;
  logic [1:0]  ip_sw;
  logic [4:0]  cause_code;
  logic [5:0]  hw_vec;
  logic        int_pend;
  logic        win_exc, win_eret, bad_from_pc, bad_from_data;
  logic [4:0]  win_code;
  logic        taken, commit, mtc0_do;
  logic [31:0] cause_value;

  always_comb begin
    hw_vec = '0;
    hw_vec[HW_INT_NUM-1:0] = hw_int;
  end

  assign int_pend = inst_valid & status_r[0] & ~status_r[1] &
                    (|({ip_hw, ip_sw} & status_r[15:8]));

  always_comb begin
    win_exc       = 1'b0;
    win_eret      = 1'b0;
    win_code      = 5'h00;
    bad_from_pc   = 1'b0;
    bad_from_data = 1'b0;
    if (int_pend) begin
      win_exc = 1'b1;
    end else if (inst_valid) begin
      if (adel_inst) begin
        win_exc = 1'b1; win_code = 5'h04; bad_from_pc = 1'b1;
      end else if (ri) begin
        win_exc = 1'b1; win_code = 5'h0a;
      end else if (overflow) begin
        win_exc = 1'b1; win_code = 5'h0c;
      end else if (syscall) begin
        win_exc = 1'b1; win_code = 5'h08;
      end else if (brk) begin
        win_exc = 1'b1; win_code = 5'h09;
      end else if (adel_data) begin
        win_exc = 1'b1; win_code = 5'h04; bad_from_data = 1'b1;
      end else if (ades) begin
        win_exc = 1'b1; win_code = 5'h05; bad_from_data = 1'b1;
      end else if (eret) begin
        win_eret = 1'b1;
      end
    end
  end

  assign taken     = win_exc | win_eret;
  assign commit    = taken & ~stall;
  assign mtc0_do   = mtc0_en & ~stall & ~taken;
  assign flush     = taken;
  assign exc_code  = win_exc ? win_code : 5'h00;
  assign pc_except = win_eret ? epc_r : EXC_VECTOR;

  assign cause_value = {cause_bd, ti, 14'b0, ip_hw, ip_sw, 1'b0, cause_code, 2'b00};
  assign status_o    = status_r;
  assign cause_o     = cause_value;
  assign epc_o       = epc_r;

  always_comb begin
    cp0_rdata = 32'h0;
    case (cp0_raddr)
      5'd8:    cp0_rdata = badvaddr_r;
      5'd9:    cp0_rdata = count_r;
      5'd11:   cp0_rdata = compare_r;
      5'd12:   cp0_rdata = status_r;
      5'd13:   cp0_rdata = cause_value;
      5'd14:   cp0_rdata = epc_r;
      default: cp0_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_r   <= RESET_STATUS;
      epc_r      <= '0;
      badvaddr_r <= '0;
      count_r    <= '0;
      compare_r  <= '0;
      cause_bd   <= 1'b0;
      ti         <= 1'b0;
      tick       <= 1'b0;
      ip_hw      <= '0;
      ip_sw      <= '0;
      cause_code <= '0;
    end else begin
      // Timer and hardware interrupt sampling run regardless of stall.
      tick <= ~tick;
      if (mtc0_do && cp0_waddr == 5'd9)
        count_r <= cp0_wdata;
      else if (tick)
        count_r <= count_r + 32'd1;
      if (mtc0_do && cp0_waddr == 5'd11) begin
        compare_r <= cp0_wdata;
        ti        <= 1'b0;
      end else if (count_r == compare_r && compare_r != 32'h0) begin
        ti <= 1'b1;
      end
      ip_hw <= hw_vec | {ti, 5'b0};

      if (commit) begin
        if (win_eret) begin
          status_r[1] <= 1'b0;
        end else begin
          // Nested exceptions keep the original return point.
          if (!status_r[1]) begin
            epc_r    <= in_delayslot ? pc - 32'd4 : pc;
            cause_bd <= in_delayslot;
          end
          status_r[1] <= 1'b1;
          cause_code  <= win_code;
          if (bad_from_pc)
            badvaddr_r <= pc;
          else if (bad_from_data)
            badvaddr_r <= bad_addr_data;
        end
      end else if (mtc0_do) begin
        case (cp0_waddr)
          5'd12:   status_r <= (status_r & ~STATUS_WMASK) | (cp0_wdata & STATUS_WMASK);
          5'd13:   ip_sw    <= cp0_wdata[9:8];
          5'd14:   epc_r    <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_exception_unit.sv
// tb/tb_exception_unit.sv - directed and randomized checks of exception_unit against a CP0 model
module tb_exception_unit;

  localparam logic [31:0] VEC  = 32'hbfc0_0380;
  localparam logic [31:0] RSTS = 32'h0040_0000;

  logic        clk, resetn, stall, inst_valid;
  logic [5:0]  hw_int;
  logic        ri, brk, syscall, overflow, adel_inst, adel_data, ades, eret, in_delayslot;
  logic [31:0] pc, bad_addr_data, cp0_wdata, cp0_rdata, pc_except, status_o, cause_o, epc_o;
  logic        mtc0_en, flush;
  logic [4:0]  cp0_waddr, cp0_raddr, exc_code;

  exception_unit #(.HW_INT_NUM(6), .EXC_VECTOR(VEC), .RESET_STATUS(RSTS)) dut (
    .clk(clk), .resetn(resetn), .stall(stall), .inst_valid(inst_valid), .hw_int(hw_int),
    .ri(ri), .brk(brk), .syscall(syscall), .overflow(overflow), .adel_inst(adel_inst),
    .adel_data(adel_data), .ades(ades), .eret(eret), .in_delayslot(in_delayslot),
    .pc(pc), .bad_addr_data(bad_addr_data), .mtc0_en(mtc0_en), .cp0_waddr(cp0_waddr),
    .cp0_wdata(cp0_wdata), .cp0_raddr(cp0_raddr), .cp0_rdata(cp0_rdata), .flush(flush),
    .pc_except(pc_except), .exc_code(exc_code), .status_o(status_o), .cause_o(cause_o),
    .epc_o(epc_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int failures = 0;

  // Architectural model: Status, Cause fields, EPC, BadVAddr, Count, Compare, TI, tick.
  logic [31:0] m_status, m_epc, m_bad, m_count, m_compare;
  logic        m_bd, m_ti, m_tick;
  logic [5:0]  m_iphw;
  logic [1:0]  m_ipsw;
  logic [4:0]  m_code;
  int          codes [9] = '{0, 4, 10, 12, 8, 9, 4, 5, 0};

  logic        s_flush;
  logic [4:0]  s_code;
  logic [31:0] s_pc, s_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] m_cause();
    return {m_bd, m_ti, 14'b0, m_iphw, m_ipsw, 1'b0, m_code, 2'b00};
  endfunction

  task automatic model_reset();
    m_status = RSTS; m_epc = 0; m_bad = 0; m_count = 0; m_compare = 0;
    m_bd = 0; m_ti = 0; m_tick = 0; m_iphw = 0; m_ipsw = 0; m_code = 0;
  endtask

  // Index into the priority list of the winning event, -1 when nothing is taken.
  function automatic int winner();
    logic [8:0] f;
    logic ip;
    ip = inst_valid && m_status[0] && !m_status[1] && (({m_iphw, m_ipsw} & m_status[15:8]) != 0);
    f = {eret, ades, adel_data, brk, syscall, overflow, ri, adel_inst, ip};
    if (!inst_valid) return -1;
    for (int i = 0; i < 9; i++) if (f[i]) return i;
    return -1;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      8:  return m_bad;
      9:  return m_count;
      11: return m_compare;
      12: return m_status;
      13: return m_cause();
      14: return m_epc;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_edge();
    int w;
    logic mt, o_ti, o_tick;
    logic [31:0] o_count, o_cmp;
    w = winner();
    o_ti = m_ti; o_tick = m_tick; o_count = m_count; o_cmp = m_compare;
    mt = mtc0_en && !stall && (w < 0);
    m_tick = !o_tick;
    if (mt && cp0_waddr == 9) m_count = cp0_wdata;
    else if (o_tick) m_count = o_count + 1;
    if (mt && cp0_waddr == 11) begin m_compare = cp0_wdata; m_ti = 0; end
    else if (o_count == o_cmp && o_cmp != 0) m_ti = 1;
    m_iphw = hw_int | {o_ti, 5'b0};
    if (!stall && w >= 0) begin
      if (w == 8) m_status[1] = 1'b0;
      else begin
        if (!m_status[1]) begin
          m_epc = in_delayslot ? pc - 4 : pc;
          m_bd  = in_delayslot;
        end
        m_status[1] = 1'b1;
        m_code = 5'(codes[w]);
        if (w == 1) m_bad = pc;
        else if (w == 6 || w == 7) m_bad = bad_addr_data;
      end
    end
    if (mt) begin
      case (cp0_waddr)
        12: m_status = (m_status & ~32'h0000_ff03) | (cp0_wdata & 32'h0000_ff03);
        13: m_ipsw = cp0_wdata[9:8];
        14: m_epc = cp0_wdata;
        default: ;
      endcase
    end
  endtask

  // One cycle: check combinational outputs mid-cycle, advance the model, check state after the edge.
  task automatic step();
    int w;
    @(negedge clk);
    w = winner();
    s_flush = flush; s_code = exc_code; s_pc = pc_except; s_rd = cp0_rdata;
    chk("flush", {31'b0, flush}, {31'b0, w >= 0});
    chk("exc_code", {27'b0, exc_code}, (w >= 0 && w < 8) ? codes[w] : 0);
    chk("pc_except", pc_except, (w == 8) ? m_epc : VEC);
    chk("cp0_rdata", cp0_rdata, m_read(cp0_raddr));
    model_edge();
    @(posedge clk);
    #1;
    chk("status", status_o, m_status);
    chk("cause", cause_o, m_cause());
    chk("epc", epc_o, m_epc);
  endtask

  task automatic clr();
    stall = 0; inst_valid = 0; ri = 0; brk = 0; syscall = 0; overflow = 0;
    adel_inst = 0; adel_data = 0; ades = 0; eret = 0; in_delayslot = 0;
    mtc0_en = 0; cp0_waddr = 0; cp0_wdata = 0;
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    clr(); mtc0_en = 1; cp0_waddr = a; cp0_wdata = d;
    step();
    mtc0_en = 0;
  endtask

  initial begin
    clr();
    hw_int = 0; pc = 0; bad_addr_data = 0; cp0_raddr = 9;
    resetn = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_status", status_o, RSTS);
    chk("rst_cause", cause_o, 32'h0);
    chk("rst_epc", epc_o, 32'h0);
    chk("rst_count", cp0_rdata, 32'h0);
    chk("rst_flush", {31'b0, flush}, 32'h0);
    chk("rst_code", {27'b0, exc_code}, 32'h0);
    chk("rst_pc_except", pc_except, VEC);
    resetn = 1;

    // syscall from a non-exception state
    inst_valid = 1; syscall = 1; pc = 32'h8000_1000;
    step();
    chk("sys_flush", {31'b0, s_flush}, 1);
    chk("sys_pc", s_pc, VEC);
    chk("sys_code", {27'b0, s_code}, 8);
    chk("sys_epc", epc_o, 32'h8000_1000);
    chk("sys_exl", {31'b0, status_o[1]}, 1);
    chk("sys_cause_code", {27'b0, cause_o[6:2]}, 8);
    clr(); inst_valid = 1; eret = 1;
    step();

    // ri beats overflow, delay slot
    clr(); inst_valid = 1; ri = 1; overflow = 1; in_delayslot = 1; pc = 32'h8000_2004;
    step();
    chk("ri_code", {27'b0, s_code}, 32'h0a);
    chk("ri_epc", epc_o, 32'h8000_2000);
    chk("ri_bd", {31'b0, cause_o[31]}, 1);
    clr(); inst_valid = 1; eret = 1;
    step();
    chk("eret_pc", s_pc, 32'h8000_2000);

    // ades then eret, BadVAddr readback
    clr(); inst_valid = 1; ades = 1; pc = 32'h8000_3000; bad_addr_data = 32'h0000_0003;
    step();
    chk("ades_code", {27'b0, s_code}, 5);
    clr(); inst_valid = 1; eret = 1; cp0_raddr = 8;
    step();
    chk("ades_bad", s_rd, 32'h3);
    chk("eret2_flush", {31'b0, s_flush}, 1);
    chk("eret2_pc", s_pc, 32'h8000_3000);
    chk("eret2_exl", {31'b0, status_o[1]}, 0);

    // hardware interrupt 0
    mtc0(12, 32'h0000_0401);
    chk("status_wr", status_o, 32'h0040_0401);
    clr(); hw_int = 6'h01;
    step();
    chk("ip2_set", {31'b0, cause_o[10]}, 1);
    step();
    chk("int_no_valid", {31'b0, s_flush}, 0);
    inst_valid = 1; pc = 32'h8000_5000;
    step();
    chk("int_flush", {31'b0, s_flush}, 1);
    chk("int_code", {27'b0, s_code}, 0);
    step();
    chk("int_exl_block", {31'b0, s_flush}, 0);
    hw_int = 0; eret = 1;
    step();

    // Count/Compare timer
    mtc0(9, 32'h0);
    mtc0(11, 32'd10);
    clr();
    for (int i = 0; i < 60 && !cause_o[15]; i++) step();
    chk("timer_ti", {31'b0, cause_o[30]}, 1);
    chk("timer_ip7", {31'b0, cause_o[15]}, 1);
    mtc0(11, 32'h0);
    chk("timer_ti_clr", {31'b0, cause_o[30]}, 0);

    // adel_inst held by stall, then commit
    clr(); inst_valid = 1; adel_inst = 1; pc = 32'h8000_4000; stall = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_flush", {31'b0, s_flush}, 1);
      chk("stall_epc", epc_o, 32'h8000_5000);
    end
    stall = 0;
    step();
    chk("adel_epc", epc_o, 32'h8000_4000);
    clr(); cp0_raddr = 8;
    step();
    chk("adel_bad", s_rd, 32'h8000_4000);

    // reset in the middle of a stalled exception
    inst_valid = 1; adel_inst = 1; stall = 1; pc = 32'h8000_6000; cp0_raddr = 9;
    step();
    #2 resetn = 0;
    #1;
    chk("mid_rst_status", status_o, RSTS);
    chk("mid_rst_cause", cause_o, 32'h0);
    chk("mid_rst_epc", epc_o, 32'h0);
    chk("mid_rst_count", cp0_rdata, 32'h0);
    model_reset();
    clr();
    @(posedge clk);
    #1 resetn = 1;

    // randomized traffic
    for (int n = 0; n < 400; n++) begin
      int sel;
      inst_valid   = ($urandom_range(0, 3) != 0);
      stall        = ($urandom_range(0, 4) == 0);
      ri           = ($urandom_range(0, 15) == 0);
      brk          = ($urandom_range(0, 15) == 0);
      syscall      = ($urandom_range(0, 15) == 0);
      overflow     = ($urandom_range(0, 15) == 0);
      adel_inst    = ($urandom_range(0, 15) == 0);
      adel_data    = ($urandom_range(0, 15) == 0);
      ades         = ($urandom_range(0, 15) == 0);
      eret         = ($urandom_range(0, 7) == 0);
      in_delayslot = 1'($urandom_range(0, 1));
      pc           = $urandom & 32'hffff_fffc;
      bad_addr_data = $urandom;
      if ($urandom_range(0, 15) == 0) hw_int = 6'($urandom);
      mtc0_en = ($urandom_range(0, 3) == 0);
      sel = $urandom_range(0, 5);
      case (sel)
        0: cp0_waddr = 9;
        1: cp0_waddr = 11;
        2: cp0_waddr = 12;
        3: cp0_waddr = 13;
        4: cp0_waddr = 14;
        default: cp0_waddr = 5'($urandom_range(0, 31));
      endcase
      cp0_wdata = (sel == 1) ? 32'($urandom_range(1, 300)) : $urandom;
      cp0_raddr = 5'($urandom_range(0, 15));
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exception_unit.md
# exception_unit

Parametrised precise-exception unit for the MIPS pipeline; it replaces the separate combinational translate and control stages. It sits at the memory (M) stage. Each cycle it prioritises the M-stage exception flags and pending interrupts, then drives the flush and redirect PC. On commit it updates its architectural CP0 state: Status, Cause, EPC, BadVAddr, Count and Compare. It also serves mfc0 reads and mtc0 writes, and generates the Count/Compare timer interrupt.

## Interface
- `HW_INT_NUM`, default 6: number of hardware interrupt lines. Legal range 1..6. Line i maps to Cause.IP[2+i].
- `EXC_VECTOR`, default 32'hbfc0_0380: redirect target for every exception except eret.
- `RESET_STATUS`, default 32'h0040_0000: Status reset value (BEV=1).
- `clk`  in  1  system clock; all state updates on the rising edge.
- `resetn`  in  1  asynchronous, active-low reset.
- `stall`  in  1  M stage held; no commit or CP0 update this cycle.
- `inst_valid`  in  1  M stage holds a real instruction (not a bubble).
- `hw_int`  in  HW_INT_NUM  level-sensitive external interrupt requests.
- `ri`, `brk`, `syscall`, `overflow`, `adel_inst`, `adel_data`, `ades`, `eret`  in  1 each  M-stage exception flags.
- `in_delayslot`  in  1  M instruction is in a branch delay slot.
- `pc`  in  32  M-stage instruction PC.
- `bad_addr_data`  in  32  data address of the M-stage load/store.
- `mtc0_en`  in  1  mtc0 write request.
- `cp0_waddr`  in  5  mtc0 register number.
- `cp0_wdata`  in  32  mtc0 write data.
- `cp0_raddr`  in  5  mfc0 register number.
- `cp0_rdata`  out  32  mfc0 read data.
- `flush`  out  1  flush all stages younger than WB and redirect fetch.
- `pc_except`  out  32  redirect target; valid when flush=1.
- `exc_code`  out  5  ExcCode of the winning event; 0 when none.
- `status_o`, `cause_o`, `epc_o`  out  32 each  current register values.

## Operation
- Pending interrupt (`int_pend`) = inst_valid & Status.IE & !Status.EXL & |(Cause.IP[7:0] & Status.IM[15:8]).
- Priority, highest first. The first true term wins:
  - int_pend → 0x00
  - adel_inst → 0x04
  - ri → 0x0a
  - overflow → 0x0c
  - syscall → 0x08
  - brk → 0x09
  - adel_data → 0x04
  - ades → 0x05
  - eret (no ExcCode; exc_code=0)
- An event is taken when any term is true and inst_valid=1.
  - flush=1.
  - pc_except = EPC if the winner is eret, else EXC_VECTOR.
- Commit happens on the clock edge when the event is taken and stall=0.
  - Exception, when Status.EXL=0 before the edge:
    - EPC ← in_delayslot ? pc-4 : pc.
    - Cause.BD ← in_delayslot.
  - Exception, always:
    - Status.EXL ← 1.
    - Cause.ExcCode ← code.
  - adel_inst: BadVAddr ← pc.
  - adel_data or ades: BadVAddr ← bad_addr_data.
  - eret: Status.EXL ← 0.
- mtc0 applies only when mtc0_en & !stall & no event is taken this cycle. A taken event suppresses mtc0.
  - Reg 9 Count: all bits.
  - Reg 11 Compare: all bits; also clears TI.
  - Reg 12 Status: IM[15:8], EXL[1], IE[0] only.
  - Reg 13 Cause: IP[1:0] only.
  - Reg 14 EPC: all bits.
  - Other writes are ignored.
- mfc0 reads are combinational from pre-edge register values.
  - Reg 8 BadVAddr, reg 9 Count, reg 11 Compare, reg 12 Status, reg 13 Cause (TI in bit 30), reg 14 EPC.
  - All other addresses read 0.
- Timer behaviour:
  - A 1-bit tick toggles every cycle; Count increments when tick=1, i.e. every 2 cycles, wrapping from 32'hffff_ffff to 0.
  - TI is set when Count == Compare and Compare != 0.
  - TI stays set until a Compare write.
- Cause.IP[7:2] is registered every cycle, independent of stall:
  - IP[2+i] ← hw_int[i].
  - IP[7] additionally ORs in TI.
  - Unused IP bits are 0.

## Timing
- Reset (resetn=0, asynchronous):
  - Status=RESET_STATUS; Cause, EPC, BadVAddr, Count, Compare, TI and tick all 0.
  - Outputs follow the reset register values: flush=0, exc_code=0, pc_except=EXC_VECTOR.
  - Reset mid-operation aborts any pending commit immediately.
- Latency and stalls:
  - flush, pc_except and exc_code have zero latency (combinational, same cycle as the flags).
  - CP0 state updates one edge later.
  - With stall=1, flush is still driven but no state changes. The event recommits when stall drops.
- hw_int latency:
  - An hw_int edge reaches Cause.IP on the next clk edge.
  - It can cause flush in the cycle after that, given IE=1, EXL=0 and the IM bit set.
- Simultaneous events:
  - An exception with EXL=1 updates ExcCode but not EPC or BD.
  - eret together with any exception: the exception wins.
  - mtc0 to Status.EXL in the same cycle as an exception is dropped.

## Test plan
- syscall with pc=0x8000_1000, EXL=0 →
  - Same cycle: flush=1, pc_except=0xbfc0_0380, exc_code=8.
  - Next cycle: EPC=0x8000_1000, Status.EXL=1, Cause.ExcCode=8.
- ri and overflow together, in_delayslot=1, pc=0x8000_2004 →
  - exc_code=0x0a.
  - EPC=0x8000_2000, Cause.BD=1.
- ades with bad_addr_data=0x0000_0003 →
  - exc_code=5, BadVAddr=3.
  - Next cycle: eret gives flush=1, pc_except=EPC and clears EXL.
- Status=0x0000_0401, hw_int[0] raised →
  - Cause.IP[2]=1 after 1 edge.
  - flush with exc_code=0 on the next valid instruction.
  - No flush when inst_valid=0 or EXL=1.
- Write Compare=10, Count=0 →
  - TI=1 and Cause.IP[7]=1 after about 20 cycles.
  - Writing Compare clears TI.
- adel_inst asserted with stall=1 for 3 cycles →
  - flush=1 throughout, EPC unchanged.
  - Commit on the first cycle stall=0.
  - Assert resetn=0 mid-stall: all registers return to reset values asynchronously.
